// File: rtl/k_fft_pkg.sv
// Shared types and constants for the radix-4 FFT sequencer.
// Sample/twiddle words pack re[7:0] in 15:8 and im[7:0] in 7:0.
package k_fft_pkg;

    localparam int K_LOG4N = 2;

    typedef struct packed {
        logic signed [7:0] re;
        logic signed [7:0] im;
    } cplx_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_CAP  = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD,
        CAP  = ST_CAP,
        WR   = ST_WR
    } state_e;

    function automatic int pow4(input int s);
        return 1 << (2 * s);
    endfunction

endpackage

// File: rtl/k_fft4_agu.sv
// Address generator: butterfly operand addresses and twiddle index
// for stage s, butterfly b, operand m of an in-place radix-4 FFT.
module k_fft4_agu
    import k_fft_pkg::*;
#(
    parameter int LOG4N = K_LOG4N,
    parameter int AW    = 2 * LOG4N,
    parameter int TW    = (LOG4N > 1) ? 2 * LOG4N - 2 : 1,
    parameter int SW    = (LOG4N > 1) ? $clog2(LOG4N) : 1
) (
    input  logic [SW-1:0] s,
    input  logic [TW-1:0] b,
    input  logic [1:0]    m,
    output logic [AW-1:0] addr,
    output logic [TW-1:0] tw_idx
);

    logic [AW-1:0] bw;
    logic [AW-1:0] msk;
    logic [AW-1:0] j;
    logic [AW-1:0] g;
    logic [AW-1:0] base;
    int            sh;

    // span is a power of four, so div/mod reduce to shift/mask
    always_comb begin
        sh     = 2 * int'(s);
        bw     = AW'(b);
        msk    = AW'(pow4(int'(s)) - 1);
        j      = bw & msk;
        g      = bw >> sh;
        base   = (g << (sh + 2)) | j;
        addr   = base + (AW'(m) << sh);
        tw_idx = TW'(j << (2 * (LOG4N - 1) - sh));
    end

endmodule

// File: rtl/k_fft4_ctrl.sv
// In-place radix-4 FFT sequencer around one shared dragonfly.
// Each butterfly: 4 reads, 1 capture cycle, 4 write-backs.
module k_fft4_ctrl
    import k_fft_pkg::*;
#(
    parameter int LOG4N = K_LOG4N,
    parameter int AW    = 2 * LOG4N,
    parameter int TW    = (LOG4N > 1) ? 2 * LOG4N - 2 : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    output logic [TW-1:0] tw_idx,
    input  logic [15:0]   tw_data,
    output logic [15:0]   df_in0,
    output logic [15:0]   df_in1,
    output logic [15:0]   df_in2,
    output logic [15:0]   df_in3,
    output logic [15:0]   df_tw,
    input  logic [15:0]   df_out0,
    input  logic [15:0]   df_out1,
    input  logic [15:0]   df_out2,
    input  logic [15:0]   df_out3
);

    localparam int SW = (LOG4N > 1) ? $clog2(LOG4N) : 1;
    localparam logic [TW-1:0] B_LAST = TW'(pow4(LOG4N - 1) - 1);
    localparam logic [SW-1:0] S_LAST = SW'(LOG4N - 1);

    state_e        state;
    logic [SW-1:0] s;
    logic [TW-1:0] b;
    logic [1:0]    m;
    logic [AW-1:0] agu_addr;
    logic [TW-1:0] agu_tw;
    logic          acc;

    k_fft4_agu #(
        .LOG4N(LOG4N),
        .AW   (AW),
        .TW   (TW),
        .SW   (SW)
    ) u_agu (
        .s     (s),
        .b     (b),
        .m     (m),
        .addr  (agu_addr),
        .tw_idx(agu_tw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            s      <= '0;
            b      <= '0;
            m      <= '0;
            done   <= 1'b0;
            df_in0 <= '0;
            df_in1 <= '0;
            df_in2 <= '0;
            df_in3 <= '0;
            df_tw  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RD;
                        s     <= '0;
                        b     <= '0;
                        m     <= '0;
                    end
                end
                RD: begin
                    // read data trails the address by one cycle
                    m <= m + 2'd1;
                    if (m == 2'd1) df_in0 <= mem_rdata;
                    if (m == 2'd2) df_in1 <= mem_rdata;
                    if (m == 2'd3) begin
                        df_in2 <= mem_rdata;
                        state  <= CAP;
                    end
                end
                CAP: begin
                    df_in3 <= mem_rdata;
                    df_tw  <= tw_data;
                    m      <= '0;
                    state  <= WR;
                end
                WR: begin
                    m <= m + 2'd1;
                    if (m == 2'd3) begin
                        if (b != B_LAST) begin
                            b     <= b + TW'(1);
                            state <= RD;
                        end else if (s != S_LAST) begin
                            b     <= '0;
                            s     <= s + SW'(1);
                            state <= RD;
                        end else begin
                            b     <= '0;
                            s     <= '0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign acc      = (state == RD) || (state == WR);
    assign busy     = (state != IDLE);
    assign mem_en   = acc;
    assign mem_we   = (state == WR);
    assign mem_addr = acc ? agu_addr : '0;
    assign tw_idx   = agu_tw;

    always_comb begin
        mem_wdata = '0;
        if (state == WR) begin
            unique case (m)
                2'd0: mem_wdata = df_out0;
                2'd1: mem_wdata = df_out1;
                2'd2: mem_wdata = df_out2;
                2'd3: mem_wdata = df_out3;
            endcase
        end
    end

endmodule

// File: tb/tb_k_fft4_ctrl.sv
// Bench for k_fft4_ctrl: sample RAM, twiddle ROM and a fixed-point
// dragonfly around the DUT, checked against a whole-transform model.
module tb_k_fft4_ctrl;
    import k_fft_pkg::*;

    localparam int L   = K_LOG4N;
    localparam int NPT = 16;
    localparam int NB  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_en, mem_we;
    logic [3:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [1:0]  tw_idx;
    logic [15:0] tw_data;
    logic [15:0] df_in0, df_in1, df_in2, df_in3, df_tw;
    logic [15:0] df_out0, df_out1, df_out2, df_out3;

    k_fft4_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .tw_idx(tw_idx), .tw_data(tw_data),
        .df_in0(df_in0), .df_in1(df_in1), .df_in2(df_in2), .df_in3(df_in3),
        .df_tw(df_tw),
        .df_out0(df_out0), .df_out1(df_out1), .df_out2(df_out2), .df_out3(df_out3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---- fixed-point complex helpers (Q2.6) ----
    function automatic int re_of(input logic [15:0] v);
        logic signed [7:0] q;
        q = v[15:8];
        return int'(q);
    endfunction

    function automatic int im_of(input logic [15:0] v);
        logic signed [7:0] q;
        q = v[7:0];
        return int'(q);
    endfunction

    function automatic logic [15:0] cmul(input logic [15:0] a, input logic [15:0] w);
        int r, i;
        r = (re_of(a) * re_of(w) - im_of(a) * im_of(w)) >>> 6;
        i = (re_of(a) * im_of(w) + im_of(a) * re_of(w)) >>> 6;
        return {r[7:0], i[7:0]};
    endfunction

    function automatic logic [15:0] pk(input int r, input int i);
        int a, c;
        a = r >>> 2;
        c = i >>> 2;
        return {a[7:0], c[7:0]};
    endfunction

    function automatic logic [3:0][15:0] dfly(input logic [3:0][15:0] x, input logic [15:0] w);
        logic [15:0]      w2, w3;
        logic [3:0][15:0] t, y;
        int               r[4], i[4];
        w2 = cmul(w, w);
        w3 = cmul(w2, w);
        t[0] = x[0];
        t[1] = cmul(x[1], w);
        t[2] = cmul(x[2], w2);
        t[3] = cmul(x[3], w3);
        for (int k = 0; k < 4; k++) begin
            r[k] = re_of(t[k]);
            i[k] = im_of(t[k]);
        end
        y[0] = pk(r[0] + r[1] + r[2] + r[3], i[0] + i[1] + i[2] + i[3]);
        y[1] = pk(r[0] + i[1] - r[2] - i[3], i[0] - r[1] - i[2] + r[3]);
        y[2] = pk(r[0] - r[1] + r[2] - r[3], i[0] - i[1] + i[2] - i[3]);
        y[3] = pk(r[0] - i[1] - r[2] + i[3], i[0] + r[1] - i[2] - r[3]);
        return y;
    endfunction

    // ---- environment: ROM, dragonfly, RAM ----
    logic [15:0] rom [4] = '{16'h4000, 16'h3BE8, 16'h2DD3, 16'h18C5};
    assign tw_data = rom[tw_idx];

    logic [3:0][15:0] dout;
    always_comb dout = dfly({df_in3, df_in2, df_in1, df_in0}, df_tw);
    assign df_out0 = dout[0];
    assign df_out1 = dout[1];
    assign df_out2 = dout[2];
    assign df_out3 = dout[3];

    logic [15:0] ram    [NPT];
    logic [15:0] ld_img [NPT];
    logic [15:0] mdl    [NPT];
    bit          ld_en = 1'b0;

    always @(posedge clk) begin
        if (ld_en) ram <= ld_img;
        else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else mem_rdata <= ram[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---- expected per-cycle behaviour ----
    typedef struct {
        bit               busy;
        bit               done;
        bit               en;
        bit               we;
        int               addr;
        int               tw;
        bit               chk_w;
        logic [15:0]      wd;
        logic [3:0][15:0] ops;
        logic [15:0]      dtw;
    } exp_t;

    typedef struct {
        bit we;
        int addr;
        int tw;
    } acc_t;

    exp_t exp_q[$];
    acc_t log_q[$];
    acc_t ref_q[$];
    int   rd_idx = 0;

    function automatic exp_t blank();
        exp_t e;
        e.busy = 0; e.done = 0; e.en = 0; e.we = 0;
        e.addr = 0; e.tw = 0; e.chk_w = 0;
        e.wd = '0; e.ops = '0; e.dtw = '0;
        return e;
    endfunction

    function automatic acc_t mk_acc(input bit we, input int a, input int t);
        acc_t r;
        r.we = we; r.addr = a; r.tw = t;
        return r;
    endfunction

    function automatic void check_cycle(input exp_t e);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        chk("mem_en", mem_en, e.en);
        chk("mem_we", mem_we, e.we);
        if (e.en) chk("mem_addr", mem_addr, e.addr);
        if (e.busy) chk("tw_idx", tw_idx, e.tw);
        if (e.chk_w) begin
            chk("mem_wdata", mem_wdata, e.wd);
            chk("df_in", {df_in3, df_in2, df_in1, df_in0}, e.ops);
            chk("df_tw", df_tw, e.dtw);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) rd_idx <= exp_q.size();
        else begin
            if (rd_idx < exp_q.size()) begin
                check_cycle(exp_q[rd_idx]);
                rd_idx <= rd_idx + 1;
            end else begin
                check_cycle(blank());
            end
            if (mem_en || mem_we)
                log_q.push_back(mk_acc(mem_we, int'(mem_addr), int'(tw_idx)));
        end
    end

    // Whole transform from the addressing rules; queues the cycle trace.
    function automatic void push_run();
        exp_t             e;
        int               span, g, j, base, tw;
        int               a[4];
        logic [3:0][15:0] x, y;
        if (rd_idx == exp_q.size()) exp_q.push_back(blank());
        for (int s = 0; s < L; s++) begin
            for (int b = 0; b < NB; b++) begin
                span = 4 ** s;
                g    = b / span;
                j    = b % span;
                base = g * 4 * span + j;
                tw   = j * (4 ** (L - 1 - s));
                for (int m = 0; m < 4; m++) begin
                    a[m] = base + m * span;
                    x[m] = mdl[a[m]];
                end
                y = dfly(x, rom[tw]);
                for (int m = 0; m < 4; m++) begin
                    e = blank(); e.busy = 1; e.en = 1; e.addr = a[m]; e.tw = tw;
                    exp_q.push_back(e);
                end
                e = blank(); e.busy = 1; e.tw = tw;
                exp_q.push_back(e);
                for (int m = 0; m < 4; m++) begin
                    e = blank(); e.busy = 1; e.en = 1; e.we = 1;
                    e.addr = a[m]; e.tw = tw; e.chk_w = 1;
                    e.wd = y[m]; e.ops = x; e.dtw = rom[tw];
                    exp_q.push_back(e);
                end
                for (int m = 0; m < 4; m++) mdl[a[m]] = y[m];
            end
        end
        e = blank(); e.done = 1;
        exp_q.push_back(e);
    endfunction

    int c0 = 0;

    task automatic load(input int kind);
        logic [15:0] v;
        for (int i = 0; i < NPT; i++) begin
            if (kind == 0) v = (i == 0) ? 16'h4000 : 16'h0000;
            else if (kind == 1) v = 16'(16'h0100 * i);
            else v = 16'($urandom);
            ld_img[i] = v;
            mdl[i] = v;
        end
        ld_en = 1'b1;
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    task automatic launch();
        start = 1'b1;
        push_run();
        c0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int x1, input int x2, output int lat);
        bit seen;
        seen = 0;
        lat = -1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); #1;
            start = ((cyc - c0) == x1) || ((cyc - c0) == x2);
            if (done) begin
                seen = 1;
                lat = cyc - c0;
            end
        end
        start = 1'b0;
        chk("done_seen", seen, 1);
    endtask

    task automatic ram_vs_model(input string nm);
        for (int i = 0; i < NPT; i++) chk(nm, ram[i], mdl[i]);
    endtask

    task automatic trace_cmp(input int lb, input string nm);
        int n, bad;
        n = log_q.size() - lb;
        bad = 0;
        chk({nm, "_len"}, n, ref_q.size());
        for (int i = 0; i < n && i < ref_q.size(); i++)
            if (log_q[lb + i].we != ref_q[i].we || log_q[lb + i].addr != ref_q[i].addr
                || log_q[lb + i].tw != ref_q[i].tw) bad++;
        chk({nm, "_diff"}, bad, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lb, nwe;
        int a0[4] = '{0, 1, 2, 3};
        int a1[4] = '{0, 4, 8, 12};
        int a2[4] = '{1, 5, 9, 13};

        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_tw_idx", tw_idx, 0);
        chk("rst_df_in", {df_in3, df_in2, df_in1, df_in0}, 0);
        chk("rst_df_tw", df_tw, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // impulse run: address trace, latency and result pinned by hand
        load(0);
        lb = log_q.size();
        launch();
        wait_done(-1, -1, lat);
        chk("latency", lat, 73);
        chk("trace_len", log_q.size() - lb, 64);
        for (int m = 0; m < 4; m++) begin
            chk("s0b0_rd_addr", log_q[lb + m].addr, a0[m]);
            chk("s0b0_rd_we", log_q[lb + m].we, 0);
            chk("s1b0_rd_addr", log_q[lb + 32 + m].addr, a1[m]);
            chk("s1b1_rd_addr", log_q[lb + 40 + m].addr, a2[m]);
        end
        chk("s1b1_tw", log_q[lb + 40].tw, 1);
        nwe = 0;
        for (int i = lb; i < log_q.size(); i++) if (log_q[i].we) nwe++;
        chk("we_cycles", nwe, 32);
        for (int i = 0; i < NPT; i++) begin
            chk("impulse_ram", ram[i], 16'h0400);
            chk("impulse_model", mdl[i], 16'h0400);
        end
        for (int i = lb; i < log_q.size(); i++) ref_q.push_back(log_q[i]);

        // addr-valued pattern: operand capture checked every WR cycle
        load(1);
        launch();
        wait_done(-1, -1, lat);
        chk("latency_pat", lat, 73);
        ram_vs_model("pattern_ram");

        // start pulses while busy are ignored
        load(2);
        lb = log_q.size();
        launch();
        wait_done(5, 40, lat);
        chk("latency_restart", lat, 73);
        trace_cmp(lb, "ignored_start_trace");
        ram_vs_model("ignored_start_ram");

        // start in the done cycle chains a second run
        load(2);
        launch();
        wait_done(-1, -1, lat);
        chk("busy_in_done", busy, 0);
        lb = log_q.size();
        launch();
        chk("busy_after_chain", busy, 1);
        wait_done(-1, -1, lat);
        chk("latency_chain", lat, 73);
        trace_cmp(lb, "chain_trace");
        ram_vs_model("chain_ram");

        // random data, random gaps
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
            load(2);
            launch();
            wait_done(-1, -1, lat);
            chk("latency_rand", lat, 73);
            ram_vs_model("rand_ram");
        end

        // reset mid-run
        load(2);
        launch();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (cyc - c0 >= 30) break;
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_mem_we", mem_we, 0);
        chk("midrst_done", done, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        lb = log_q.size();
        repeat (100) @(posedge clk);
        #1;
        chk("post_rst_accesses", log_q.size() - lb, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
